dcache_direct_mapped: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and a line-wide backing data memory.
- Accepts one word request at a time over a valid/ready handshake.
- Misses go through a small FSM that writes back a dirty victim line, then allocates the new line.
- Replaces the single-cycle data-memory path once memory access becomes multi-cycle.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_line_array.sv | 53 +++++
 rtl/dcache_direct_mapped.sv | 216 +++++++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM encodings and address helpers
// for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_COMPARE    = 2'd1;
    localparam logic [1:0] ST_WRITE_BACK = 2'd2;
    localparam logic [1:0] ST_ALLOCATE   = 2'd3;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int line_words, input int num_lines);
        return 32 - idx_w(num_lines) - off_w(line_words);
    endfunction

    function automatic logic [31:0] line_addr(
        input logic [31:0] a,
        input int          offw
    );
        return a & ~((32'h1 << offw) - 32'h1);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: per-line tag, valid, dirty and data registers.
// Combinational read by index, one full-line write per clock.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    localparam int IDX_W     = idx_w(NUM_LINES),
    localparam int TAG_W     = tag_w(LINE_WORDS, NUM_LINES),
    localparam int LINE_BITS = 32 * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic                 wr_dirty,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // Every write leaves the line valid; only the dirty bit varies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped: direct-mapped write-back, write-allocate cache.
// Define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    localparam int OFF_W     = off_w(LINE_WORDS),
    localparam int IDX_W     = idx_w(NUM_LINES),
    localparam int TAG_W     = tag_w(LINE_WORDS, NUM_LINES),
    localparam int LINE_BITS = 32 * LINE_WORDS,
    localparam int WORD_W    = OFF_W - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_input_valid,
    input  logic [31:0]          addr,
    input  logic                 mem_rw,
    input  logic [31:0]          din,
    output logic                 is_ready,
    output logic                 is_output_valid,
    output logic [31:0]          dout,
    output logic                 is_hit,
    output logic                 mem_req_valid,
    output logic                 mem_req_write,
    output logic [31:0]          mem_req_addr,
    output logic [LINE_BITS-1:0] mem_req_data,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    logic [1:0]  state;
    logic [31:0] req_addr;
    logic [31:0] req_din;
    logic        req_rw;
    logic        missed;
    logic        req_sent;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;

    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_word = req_addr[2 +: WORD_W];

    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 wr_en;
    logic                 wr_dirty;
    logic [TAG_W-1:0]     wr_tag;
    logic [LINE_BITS-1:0] wr_data;

    dcache_line_array #(
        .LINE_WORDS(LINE_WORDS),
        .NUM_LINES (NUM_LINES)
    ) u_lines (
        .clk     (clk),
        .reset   (reset),
        .idx     (req_idx),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_dirty(wr_dirty),
        .wr_tag  (wr_tag),
        .wr_data (wr_data)
    );

    logic                 hit;
    logic                 accept;
    logic                 in_mem;
    logic                 req_fire;
    logic                 resp_take;
    logic [31:0]          rd_word;
    logic [LINE_BITS-1:0] merged;

    assign hit      = (state == ST_COMPARE) && rd_valid
                      && (rd_tag == req_tag);
    assign accept   = is_input_valid && is_ready;
    assign in_mem   = (state == ST_WRITE_BACK)
                      || (state == ST_ALLOCATE);
    assign req_fire = mem_req_valid && mem_req_ready;
    // A response only counts once its request has been (or is being) taken.
    assign resp_take = in_mem && mem_resp_valid
                       && (req_sent || req_fire);

    always_comb begin
        rd_word = '0;
        merged  = rd_data;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (w == int'(req_word)) begin
                rd_word             = rd_data[w*32 +: 32];
                merged[w*32 +: 32]  = req_din;
            end
        end
    end

    assign is_ready        = (state == ST_IDLE);
    assign is_output_valid = hit;
    assign is_hit          = hit && !missed;
    assign dout            = (hit && !req_rw) ? rd_word : 32'h0;

    assign mem_req_valid = in_mem && !req_sent;
    assign mem_req_write = mem_req_valid
                           && (state == ST_WRITE_BACK);

    always_comb begin
        mem_req_addr = 32'h0;
        mem_req_data = '0;
        if (mem_req_valid) begin
            if (state == ST_WRITE_BACK) begin
                mem_req_addr = {rd_tag, req_idx, {OFF_W{1'b0}}};
                mem_req_data = rd_data;
            end else begin
                mem_req_addr = line_addr(req_addr, OFF_W);
            end
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_dirty = 1'b0;
        wr_tag   = rd_tag;
        wr_data  = rd_data;
        case (state)
            ST_COMPARE: begin
                if (hit && req_rw) begin
                    wr_en    = 1'b1;
                    wr_dirty = 1'b1;
                    wr_data  = merged;
                end
            end
            ST_WRITE_BACK: begin
                wr_en = resp_take;
            end
            ST_ALLOCATE: begin
                wr_en   = resp_take;
                wr_tag  = req_tag;
                wr_data = mem_resp_data;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            req_addr <= 32'h0;
            req_din  <= 32'h0;
            req_rw   <= 1'b0;
            missed   <= 1'b0;
            req_sent <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_addr <= addr;
                        req_din  <= din;
                        req_rw   <= mem_rw;
                        missed   <= 1'b0;
                        state    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit) begin
                        state <= ST_IDLE;
                    end else begin
                        missed <= 1'b1;
                        state  <= (rd_valid && rd_dirty)
                                  ? ST_WRITE_BACK : ST_ALLOCATE;
                    end
                end
                ST_WRITE_BACK: begin
                    if (req_fire) req_sent <= 1'b1;
                    if (resp_take) begin
                        req_sent <= 1'b0;
                        state    <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (req_fire) req_sent <= 1'b1;
                    if (resp_take) begin
                        req_sent <= 1'b0;
                        state    <= ST_COMPARE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else if (is_output_valid) begin
            if (is_hit) hit_count  <= hit_count + 32'h1;
            else        miss_count <= miss_count + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb_dcache_direct_mapped: directed vectors against a line-wide
// backing memory model with programmable ready/response delays.
module tb_dcache_direct_mapped;

    logic         clk;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_rw;
    logic [31:0]  din;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         mem_req_valid;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    dcache_direct_mapped dut (
        .clk            (clk),
        .reset          (reset),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_rw         (mem_rw),
        .din            (din),
        .is_ready       (is_ready),
        .is_output_valid(is_output_valid),
        .dout           (dout),
        .is_hit         (is_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic         rw;
        logic [31:0]  din;
        int           rdly;
        int           sdly;
        logic [31:0]  dout;
        logic         hit;
        logic         wb;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        logic         fe;
        logic [31:0]  fe_addr;
    } vec_t;

    vec_t vecs [9];

    int total = 0;
    int bad   = 0;

    logic [127:0] mem [logic [31:0]];
    int           wb_n;
    int           fe_n;
    logic [31:0]  wb_addr_q;
    logic [127:0] wb_data_q;
    logic [31:0]  fe_addr_q;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a + 32'hC, a + 32'h8, a + 32'h4, a};
    endfunction

    task automatic respond(input logic [31:0] a, input logic w,
                           input logic [127:0] d);
        mem_resp_valid = 1'b1;
        if (w) begin
            mem[a]        = d;
            mem_resp_data = '0;
        end else begin
            mem_resp_data = mem_rd(a);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic rw,
                         input logic [31:0] d);
        @(negedge clk);
        chk("ready_before_req", is_ready, 1);
        is_input_valid = 1'b1;
        addr           = a;
        mem_rw         = rw;
        din            = d;
        wb_n           = 0;
        fe_n           = 0;
        @(posedge clk);
        #1;
        is_input_valid = 1'b0;
    endtask

    task automatic service(input int rdly, input int sdly,
                           output logic ok, output int cyc,
                           output logic [31:0] rdata, output logic rhit);
        int          wcnt = 0;
        int          rcnt = 0;
        logic        pend = 0;
        logic [31:0] pa   = 0;
        logic        pw   = 0;
        logic [127:0] pd  = 0;
        ok = 0; cyc = -1; rdata = 0; rhit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (is_output_valid) begin
                ok = 1; cyc = c; rdata = dout; rhit = is_hit;
                break;
            end
            if (pend) begin
                if (rcnt == sdly) begin
                    respond(pa, pw, pd);
                    pend = 0;
                end else rcnt++;
            end else if (mem_req_valid) begin
                if (wcnt == rdly) begin
                    mem_req_ready = 1'b1;
                    wcnt = 0;
                    if (mem_req_write) begin
                        wb_n++;
                        wb_addr_q = mem_req_addr;
                        wb_data_q = mem_req_data;
                    end else begin
                        fe_n++;
                        fe_addr_q = mem_req_addr;
                    end
                    if (sdly < 0) begin
                        respond(mem_req_addr, mem_req_write, mem_req_data);
                    end else begin
                        pend = 1; rcnt = 0;
                        pa = mem_req_addr; pw = mem_req_write;
                        pd = mem_req_data;
                    end
                end else wcnt++;
            end
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input string nm,
                             input logic ok, input int cyc,
                             input logic [31:0] rdata, input logic rhit);
        chk({nm, "_done"}, ok, 1);
        chk({nm, "_dout"}, rdata, v.dout);
        chk({nm, "_is_hit"}, rhit, v.hit);
        chk({nm, "_wb_cnt"}, wb_n, v.wb ? 1 : 0);
        chk({nm, "_fetch_cnt"}, fe_n, v.fe ? 1 : 0);
        if (v.wb) begin
            chk({nm, "_wb_addr"}, wb_addr_q, v.wb_addr);
            chk({nm, "_wb_data"}, wb_data_q, v.wb_data);
        end
        if (v.fe) chk({nm, "_fetch_addr"}, fe_addr_q, v.fe_addr);
        if (v.hit) chk({nm, "_hit_latency"}, cyc, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic        ok;
        int          cyc;
        logic [31:0] rdata;
        logic        rhit;
        issue(v.addr, v.rw, v.din);
        service(v.rdly, v.sdly, ok, cyc, rdata, rhit);
        check_vec(v, nm, ok, cyc, rdata, rhit);
    endtask

    initial begin
        vec_t        v;
        logic        ok;
        int          cyc;
        logic [31:0] rdata;
        logic        rhit;

        reset = 1'b1; is_input_valid = 1'b0; addr = 0; mem_rw = 0; din = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        wb_n = 0; fe_n = 0; wb_addr_q = 0; wb_data_q = 0; fe_addr_q = 0;
        mem[32'h10] = {32'd4, 32'd3, 32'd2, 32'd1};

        vecs[0] = '{32'h10, 0, 0, 1, 2, 32'h1, 0,
                    0, 0, 0, 1, 32'h10};
        vecs[1] = '{32'h14, 0, 0, 0, 0, 32'h2, 1,
                    0, 0, 0, 0, 0};
        vecs[2] = '{32'h10, 1, 32'hDEADBEEF, 0, 0, 0, 1,
                    0, 0, 0, 0, 0};
        vecs[3] = '{32'h410, 0, 0, 0, -1, 32'h410, 0,
                    1, 32'h10, {32'd4, 32'd3, 32'd2, 32'hDEADBEEF},
                    1, 32'h410};
        vecs[4] = '{32'h10, 0, 0, 2, 0, 32'hDEADBEEF, 0,
                    0, 0, 0, 1, 32'h10};
        vecs[5] = '{32'h824, 1, 32'h12345678, 0, 1, 0, 0,
                    0, 0, 0, 1, 32'h820};
        vecs[6] = '{32'h824, 0, 0, 0, 0, 32'h12345678, 1,
                    0, 0, 0, 0, 0};
        vecs[7] = '{32'h828, 0, 0, 0, 0, 32'h828, 1,
                    0, 0, 0, 0, 0};
        vecs[8] = '{32'h1024, 0, 0, 1, 1, 32'h1024, 0,
                    1, 32'h820,
                    {32'h82C, 32'h828, 32'h12345678, 32'h820},
                    1, 32'h1020};

        repeat (2) @(negedge clk);
        chk("rst_is_ready", is_ready, 1);
        chk("rst_out_valid", is_output_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_is_hit", is_hit, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_write", mem_req_write, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_req_data", mem_req_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef DCACHE_STATS_EN
        chk("stats_hits", hit_count, 4);
        chk("stats_misses", miss_count, 5);
`endif

        // Fetch stalled by mem_req_ready low; CPU requests must be ignored.
        issue(32'h30, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_req_valid", mem_req_valid, 1);
            chk("stall_req_write", mem_req_write, 0);
            chk("stall_req_addr", mem_req_addr, 32'h30);
            chk("stall_is_ready", is_ready, 0);
            is_input_valid = 1'b1; addr = 32'h50; mem_rw = 1; din = 32'h55;
        end
        is_input_valid = 1'b0;
        service(0, 1, ok, cyc, rdata, rhit);
        v = '{32'h30, 0, 0, 0, 1, 32'h30, 0, 0, 0, 0, 1, 32'h30};
        check_vec(v, "stall", ok, cyc, rdata, rhit);

        v = '{32'h34, 1, 32'hAA, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        run_vec(v, "dirty34");

        // Reset while the dirty victim is being written back.
        issue(32'h430, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("wb_req_valid", mem_req_valid, 1);
        chk("wb_req_write", mem_req_write, 1);
        chk("wb_req_addr", mem_req_addr, 32'h30);
        reset = 1'b1;
        #1;
        chk("abort_req_valid", mem_req_valid, 0);
        chk("abort_is_ready", is_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {4{32'hBAD0BAD0}};
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stale_out_valid", is_output_valid, 0);
        chk("stale_is_ready", is_ready, 1);
        chk("stale_req_valid", mem_req_valid, 0);

        v = '{32'h30, 0, 0, 0, 0, 32'h30, 0, 0, 0, 0, 1, 32'h30};
        run_vec(v, "post_rst30");
        v = '{32'h14, 0, 0, 0, 0, 32'h2, 0, 0, 0, 0, 1, 32'h10};
        run_vec(v, "post_rst14");

`ifdef DCACHE_STATS_EN
        chk("stats_rst_hits", hit_count, 0);
        chk("stats_rst_misses", miss_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
